// File: rtl/spi_register_file_pkg.sv
// Shared types and helpers for the SPI-addressed register bank.
// Registers are at most 4 bytes, so helpers work on a fixed 32-bit container.
package spi_register_file_pkg;

    localparam int MAX_REG_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_IGNORE
    } state_e;

    function automatic logic addr_in_range(input logic [7:0] opcode, input int base, input int n);
        return (int'(opcode) >= base) && (int'(opcode) < base + n);
    endfunction

    // Byte sent at transfer position idx, MSB first; positions past the register read as zero.
    function automatic logic [7:0] byte_slice(input logic [MAX_REG_W-1:0] value, input int idx,
                                              input int nbytes);
        logic [MAX_REG_W-1:0] shifted;
        if (idx >= nbytes) return 8'h00;
        shifted = value >> (8 * (nbytes - 1 - idx));
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// One-flop edge detector: compares the live level against its value one cycle earlier.
module spi_edge_detect (
    input  logic clock_in,
    input  logic reset_in,
    input  logic level_in,
    output logic rise_out,
    output logic fall_out
);

    logic level_q;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_in;
        end
    end

    assign rise_out = level_in & ~level_q;
    assign fall_out = ~level_in & level_q;

endmodule

// File: rtl/spi_register_file.sv
// Bank of NUM_REGS multi-byte registers answering SPI opcodes BASE_ADDRESS..BASE_ADDRESS+NUM_REGS-1.
// Reads come from a snapshot taken at opcode receipt; writes commit atomically when chip-select drops.
module spi_register_file
    import spi_register_file_pkg::*;
#(
    parameter int                            BASE_ADDRESS  = 'hD0,
    parameter int                            NUM_REGS      = 4,
    parameter int                            REG_BYTES     = 2,
    parameter logic [NUM_REGS-1:0]           WRITABLE_MASK = '1,
    parameter logic [NUM_REGS*REG_BYTES*8-1:0] RESET_VALUES = '0
) (
    input  logic                              clock_in,
    input  logic                              reset_in,
    input  logic [7:0]                        opcode_in,
    input  logic                              opcode_valid_in,
    input  logic [7:0]                        operand_in,
    input  logic                              operand_valid_in,
    input  logic [NUM_REGS*REG_BYTES*8-1:0]   hw_value_in,
    output logic [7:0]                        response_out,
    output logic                              response_valid_out,
    output logic [NUM_REGS*REG_BYTES*8-1:0]   regs_out,
    output logic [NUM_REGS-1:0]               write_strobe_out
);

    localparam int REG_W   = REG_BYTES * 8;
    localparam int TOTAL_W = NUM_REGS * REG_W;
    localparam int IDX_W   = $clog2(REG_BYTES + 1);
    localparam int SEL_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic opc_rise, opc_fall, opd_rise, opd_fall_unused;

    spi_edge_detect u_opcode_edge (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .level_in (opcode_valid_in),
        .rise_out (opc_rise),
        .fall_out (opc_fall)
    );

    spi_edge_detect u_operand_edge (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .level_in (operand_valid_in),
        .rise_out (opd_rise),
        .fall_out (opd_fall_unused)
    );

    state_e             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [REG_W-1:0]   snapshot_q, shadow_q, shadow_d, entry_value;
    logic [TOTAL_W-1:0] regs_q;
    logic [7:0]         response_q;
    logic               response_valid_q;
    logic [NUM_REGS-1:0] strobe_q;
    logic [SEL_W-1:0]   opc_sel;
    logic               commit_ok;

    assign opc_sel = SEL_W'(opcode_in - 8'(BASE_ADDRESS));

    always_comb begin
        entry_value = WRITABLE_MASK[opc_sel] ? regs_q[int'(opc_sel)*REG_W +: REG_W]
                                             : hw_value_in[int'(opc_sel)*REG_W +: REG_W];
    end

    // The byte arriving with this cycle's operand rise is folded in before any commit check,
    // so a final byte coinciding with chip-select release still completes the write.
    always_comb begin
        index_d  = index_q;
        shadow_d = shadow_q;
        if (opd_rise && int'(index_q) < REG_BYTES) begin
            index_d = index_q + IDX_W'(1);
            for (int b = 0; b < REG_BYTES; b++) begin
                if (int'(index_q) == b) shadow_d[8*(REG_BYTES-1-b) +: 8] = operand_in;
            end
        end
    end

    assign commit_ok = (index_d == IDX_W'(REG_BYTES)) && WRITABLE_MASK[sel_q];

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q          <= ST_IDLE;
            sel_q            <= '0;
            index_q          <= '0;
            snapshot_q       <= '0;
            shadow_q         <= '0;
            // NOTE: the register bank is plain flops, not a RAM, so it can take its reset image directly.
            regs_q           <= RESET_VALUES;
            response_q       <= 8'h00;
            response_valid_q <= 1'b0;
            strobe_q         <= '0;
        end else begin
            // NOTE: default-then-override keeps the strobe a single-cycle pulse without extra state.
            strobe_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (opc_rise) begin
                        if (addr_in_range(opcode_in, BASE_ADDRESS, NUM_REGS)) begin
                            state_q          <= ST_ACTIVE;
                            sel_q            <= opc_sel;
                            index_q          <= '0;
                            shadow_q         <= '0;
                            snapshot_q       <= entry_value;
                            response_valid_q <= 1'b1;
                            response_q       <= byte_slice(MAX_REG_W'(entry_value), 0, REG_BYTES);
                        end else begin
                            state_q <= ST_IGNORE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    index_q    <= index_d;
                    shadow_q   <= shadow_d;
                    response_q <= byte_slice(MAX_REG_W'(snapshot_q), int'(index_d), REG_BYTES);
                    if (opc_fall) begin
                        state_q          <= ST_IDLE;
                        index_q          <= '0;
                        response_valid_q <= 1'b0;
                        response_q       <= 8'h00;
                        if (commit_ok) begin
                            regs_q[int'(sel_q)*REG_W +: REG_W] <= shadow_d;
                            strobe_q[sel_q]                    <= 1'b1;
                        end
                    end
                end
                ST_IGNORE: begin
                    if (opc_fall) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read-only slices are never written, but are masked so downstream logic sees zero there.
    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_out[i*REG_W +: REG_W] = WRITABLE_MASK[i] ? regs_q[i*REG_W +: REG_W] : '0;
        end
    end

    assign response_out       = response_q;
    assign response_valid_out = response_valid_q;
    assign write_strobe_out   = strobe_q;

endmodule

// File: tb/tb_spi_register_file.sv
// Directed bench for spi_register_file: expectations are queued as stimulus is applied
// and popped when the corresponding output is sampled on the falling clock edge.
module tb_spi_register_file;

    localparam int          NUM_REGS     = 4;
    localparam int          REG_BYTES    = 2;
    localparam int          TOTAL_W      = NUM_REGS * REG_BYTES * 8;
    localparam logic [3:0]  MASK         = 4'b0111;
    localparam logic [63:0] RESET_VALUES = 64'hCAFE_2468_BEEF_1357;

    logic               clock_in = 1'b0;
    logic               reset_in;
    logic [7:0]         opcode_in;
    logic               opcode_valid_in;
    logic [7:0]         operand_in;
    logic               operand_valid_in;
    logic [TOTAL_W-1:0] hw_value_in;
    logic [7:0]         response_out;
    logic               response_valid_out;
    logic [TOTAL_W-1:0] regs_out;
    logic [3:0]         write_strobe_out;

    spi_register_file #(
        .BASE_ADDRESS  ('hD0),
        .NUM_REGS      (NUM_REGS),
        .REG_BYTES     (REG_BYTES),
        .WRITABLE_MASK (MASK),
        .RESET_VALUES  (RESET_VALUES)
    ) dut (
        .clock_in           (clock_in),
        .reset_in           (reset_in),
        .opcode_in          (opcode_in),
        .opcode_valid_in    (opcode_valid_in),
        .operand_in         (operand_in),
        .operand_valid_in   (operand_valid_in),
        .hw_value_in        (hw_value_in),
        .response_out       (response_out),
        .response_valid_out (response_valid_out),
        .regs_out           (regs_out),
        .write_strobe_out   (write_strobe_out)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        string       tag;
        logic [63:0] value;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] model_regs;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic push(input string tag, input logic [63:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic check_pop(input logic [63:0] observed);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%h", observed);
            return;
        end
        e = exp_q.pop_front();
        assert (observed === e.value)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
        end
    endtask

    task automatic check_resp();   check_pop(64'(response_out));       endtask
    task automatic check_rv();     check_pop(64'(response_valid_out)); endtask
    task automatic check_strobe(); check_pop(64'(write_strobe_out));   endtask
    task automatic check_regs();   check_pop(64'(regs_out));           endtask

    task automatic operand_pulse(input logic [7:0] b);
        operand_in       = b;
        operand_valid_in = 1'b1;
        tick();
        operand_valid_in = 1'b0;
        tick();
    endtask

    task automatic opcode_rise(input logic [7:0] op);
        opcode_in       = op;
        opcode_valid_in = 1'b1;
    endtask

    initial begin
        reset_in         = 1'b1;
        opcode_in        = 8'h00;
        opcode_valid_in  = 1'b0;
        operand_in       = 8'h00;
        operand_valid_in = 1'b0;
        hw_value_in      = 64'h5A5A_1111_2222_3333;
        model_regs       = RESET_VALUES & 64'h0000_FFFF_FFFF_FFFF;

        // Reset
        tick(3);
        reset_in = 1'b0;
        tick();
        push("reset_regs", model_regs);  check_regs();
        push("reset_valid", 64'h0);      check_rv();
        push("reset_strobe", 64'h0);     check_strobe();
        push("reset_resp", 64'h0);       check_resp();

        // Read reg1, writing back the same bytes
        opcode_rise(8'hD1);
        push("rd1_valid", 64'h1);
        tick();                          check_rv();
        tick();
        push("rd1_byte0", 64'hBE);       check_resp();
        push("rd1_byte1", 64'hEF);       operand_pulse(8'hBE); check_resp();
        push("rd1_past_end", 64'h00);    operand_pulse(8'hEF); check_resp();
        opcode_valid_in = 1'b0;
        push("rd1_valid_drop", 64'h0);
        push("rd1_strobe", 64'h2);
        tick();                          check_rv(); check_strobe();
        push("rd1_strobe_once", 64'h0);
        push("rd1_regs", model_regs);
        tick();                          check_strobe(); check_regs();

        // Full write of reg2 with an extra byte beyond the register width
        opcode_rise(8'hD2);
        tick(2);
        push("wr2_byte0", 64'h24);       check_resp();
        push("wr2_byte1", 64'h68);       operand_pulse(8'h12); check_resp();
        push("wr2_end", 64'h00);         operand_pulse(8'h34); check_resp();
        push("wr2_extra", 64'h00);       operand_pulse(8'h56); check_resp();
        opcode_valid_in = 1'b0;
        model_regs[32 +: 16] = 16'h1234;
        push("wr2_strobe", 64'h4);
        tick();                          check_strobe();
        push("wr2_strobe_once", 64'h0);
        push("wr2_regs", model_regs);
        tick();                          check_strobe(); check_regs();

        // Short write to reg0 is discarded
        opcode_rise(8'hD0);
        tick(2);
        operand_pulse(8'hAA);
        opcode_valid_in = 1'b0;
        push("short_strobe", 64'h0);
        tick();                          check_strobe();
        push("short_strobe_late", 64'h0);
        push("short_regs", model_regs);
        tick();                          check_strobe(); check_regs();

        // Last byte arrives in the same cycle as chip-select release
        opcode_rise(8'hD0);
        tick(2);
        operand_pulse(8'hAB);
        operand_in       = 8'hCD;
        operand_valid_in = 1'b1;
        opcode_valid_in  = 1'b0;
        model_regs[0 +: 16] = 16'hABCD;
        push("simul_strobe", 64'h1);
        tick();                          check_strobe();
        operand_valid_in = 1'b0;
        push("simul_strobe_once", 64'h0);
        push("simul_regs", model_regs);
        tick();                          check_strobe(); check_regs();

        // Read-only reg3: snapshot holds across a live change, write is dropped
        opcode_rise(8'hD3);
        tick(2);
        push("ro_byte0", 64'h5A);        check_resp();
        hw_value_in[48 +: 16] = 16'hA5C3;
        push("ro_byte1", 64'h5A);        operand_pulse(8'hFF); check_resp();
        push("ro_end", 64'h00);          operand_pulse(8'hFF); check_resp();
        opcode_valid_in = 1'b0;
        push("ro_strobe", 64'h0);
        push("ro_valid_drop", 64'h0);
        tick();                          check_strobe(); check_rv();
        push("ro_regs", model_regs);
        tick();                          check_regs();

        // Out-of-range opcodes below and just above the window
        opcode_rise(8'hC7);
        push("oor_low_valid", 64'h0);
        push("oor_low_resp", 64'h0);
        tick();                          check_rv(); check_resp();
        push("oor_low_valid_op", 64'h0); operand_pulse(8'h11); check_rv();
        opcode_valid_in = 1'b0;
        tick();
        opcode_rise(8'hD4);
        push("oor_high_valid", 64'h0);
        tick(2);                         check_rv();
        opcode_valid_in = 1'b0;
        tick();

        // Reset in the middle of a write to reg2
        opcode_rise(8'hD2);
        tick(2);
        operand_pulse(8'h99);
        reset_in        = 1'b1;
        opcode_valid_in = 1'b0;
        model_regs      = RESET_VALUES & 64'h0000_FFFF_FFFF_FFFF;
        push("rst_strobe", 64'h0);
        push("rst_regs", model_regs);
        push("rst_valid", 64'h0);
        tick();                          check_strobe(); check_regs(); check_rv();
        reset_in = 1'b0;
        tick();

        // Pure read of reg2 returns its reset value, then an immediate back-to-back read of reg1
        opcode_rise(8'hD2);
        push("post_rst_valid", 64'h1);
        tick();                          check_rv();
        push("post_rst_byte0", 64'h24);
        tick();                          check_resp();
        opcode_valid_in = 1'b0;
        push("pure_read_strobe", 64'h0);
        tick();                          check_strobe();
        opcode_rise(8'hD1);
        push("b2b_valid", 64'h1);
        tick();                          check_rv();
        push("b2b_byte0", 64'hBE);
        tick();                          check_resp();
        opcode_valid_in = 1'b0;
        push("b2b_valid_drop", 64'h0);
        tick();                          check_rv();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover remaining=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
